cpu_control_unit: RTL
=====================

Name: cpu_control_unit

Overview:
- Multi-cycle fetch/decode/execute controller for the 8-bit datapath.
- Sits directly upstream of the ALU:
  - drives the ALU operation select, operand-mux selects and register load enables;
  - latches the ALU z/n/c/v outputs into a status register;
  - uses that register for conditional jumps.
- Fetches 16-bit instructions from a synchronous-read instruction memory.

Parameters:
- PC_W, 8, program counter and instruction-address width; jump target is literal[PC_W-1:0].
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  level; while high, the FSM leaves IDLE and executes.
- imem_addr  out  PC_W  instruction address; always equals pc.
- imem_data  in  16  instruction word, valid one cycle after imem_addr is presented.
- alu_s  out  3  ALU operation select, taken from ir[13:11].
- sel_b  out  1  ALU second operand: 0 = register B, 1 = literal.
- sel_a  out  1  ALU first operand: 0 = register A, 1 = register B.
- lit  out  8  ir[7:0], driven to the datapath.
- la  out  1  load register A with the ALU result.
- lb  out  1  load register B with the ALU result.
- z, n, c, v  in  1 each  ALU flags, combinational from the current operands.
- status  out  4  latched {z,n,c,v}.
- pc  out  PC_W  current program counter.
- halted  out  1  high in HALT.

Behaviour:
- Reset is asynchronous and active-high:
  - state=IDLE, pc=RESET_PC, ir=0, status=0;
  - la, lb, sel_a, sel_b = 0, alu_s=0, halted=0.
  - Reset asserted mid-instruction aborts it with no register load and no pc change.
- Instruction format: ir[15:14] class, ir[13:11] alu op, ir[10:8] sub-field, ir[7:0] literal.
- States:
  - IDLE: go to FETCH if run is high, else stay.
  - FETCH: imem_addr=pc; go to DECODE.
  - DECODE: ir<=imem_data; go to EXEC.
  - EXEC: perform the instruction; go to FETCH if run is high, else IDLE. HALT instructions go to HALT instead.
  - HALT: halted=1; only rst leaves this state.
- Throughput: 3 cycles per instruction. run is sampled only in IDLE and at the end of EXEC.
- Strobes: la, lb and status writes are asserted only in EXEC and last one cycle. alu_s, sel_a, sel_b and lit are valid in EXEC and held at 0 elsewhere.
- Class 00, ALU → A:
  - la=1, sel_a=0.
  - sub 000: operand B; sub 001: literal (sel_b=1).
  - Other sub values: NOP.
- Class 01, ALU → B:
  - lb=1, sel_a=1.
  - sub 000: operand B; sub 001: literal.
  - Other sub values: NOP.
- Every executed ALU-class instruction sets status<={z,n,c,v} at the end of EXEC.
- ALU-class instructions increment pc by 1; pc wraps from 2^PC_W-1 to 0.
- Class 10, jump. Condition by sub:
  - 000 always
  - 001 z
  - 010 !z
  - 011 !n&!z
  - 100 n
  - 101 !n
  - 110 n|z
  - 111 c
  - Conditions are evaluated on the latched status, not on the live flags.
  - Taken: pc<=lit[PC_W-1:0]. Not taken: pc+1.
  - status is unchanged.
- Class 11, misc: sub 000 = NOP (pc+1); sub 111 = HALT (pc unchanged); other sub values = NOP.
- NOP-decoded encodings assert no load and no status write.

Optional Feature:
- Macro: CPU_SINGLE_STEP_EN.
- Defined:
  - adds input port step;
  - after EXEC the FSM enters a STEP_WAIT state (halted=0) instead of going to FETCH;
  - STEP_WAIT goes to FETCH on a cycle where step is high.
  - run has no effect on leaving STEP_WAIT.
- Undefined: no step port and no STEP_WAIT state; behaviour exactly as described above.

Decomposition:
- Shared package cpu_pkg holds:
  - state enum;
  - class codes CLS_ALU_A, CLS_ALU_B, CLS_JMP, CLS_MISC;
  - ALU op constants (ADD=000 … SHR=111);
  - jump condition codes;
  - sub-codes SRC_B, SRC_LIT, MISC_NOP, MISC_HALT.
- One natural sub-module: cpu_branch_cond, a combinational block (4-bit status + 3-bit cond → taken).

Test Plan:
1. Program: 0x0105 (ADD A,#5), then 0x0103 (ADD A,#3), with run=1 → la pulses in cycles 3 and 6 with alu_s=000, sel_b=1, lit=05 then 03; pc goes 0→1→2.
2. After an instruction whose ALU output is 0 (z=1 at EXEC) → status=1000. Then JEQ 0x8910 (class 10, sub 001, lit 0x10) → pc=0x10. With status z=0, the same instruction → pc+1.
3. JMP 0x80FF followed by any ALU instruction at address 0xFF → pc wraps to 0x00.
4. HALT (0xC700) → halted=1 two cycles after the DECODE latches it; pc frozen, no la/lb. Toggling run has no effect; rst clears halted and pc=0.
5. Assert rst during the DECODE of a load instruction → no la pulse; state IDLE, pc=0, status=0 immediately.
6. With CPU_SINGLE_STEP_EN: after the first EXEC, imem_addr holds for 10 cycles with step=0; a one-cycle step pulse → the next FETCH follows.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and encodings for the multi-cycle CPU controller.
// Optional single-step support is enabled with CPU_SINGLE_STEP_EN.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
`ifdef CPU_SINGLE_STEP_EN
    , ST_STEP_WAIT = 3'd5
`endif
  } state_t;

  localparam logic [1:0] CLS_ALU_A = 2'b00;
  localparam logic [1:0] CLS_ALU_B = 2'b01;
  localparam logic [1:0] CLS_JMP   = 2'b10;
  localparam logic [1:0] CLS_MISC  = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOT = 3'b101;
  localparam logic [2:0] ALU_SHL = 3'b110;
  localparam logic [2:0] ALU_SHR = 3'b111;

  localparam logic [2:0] JC_ALWAYS = 3'b000;
  localparam logic [2:0] JC_Z      = 3'b001;
  localparam logic [2:0] JC_NZ     = 3'b010;
  localparam logic [2:0] JC_GT     = 3'b011;
  localparam logic [2:0] JC_N      = 3'b100;
  localparam logic [2:0] JC_NN     = 3'b101;
  localparam logic [2:0] JC_LE     = 3'b110;
  localparam logic [2:0] JC_C      = 3'b111;

  localparam logic [2:0] SRC_B     = 3'b000;
  localparam logic [2:0] SRC_LIT   = 3'b001;
  localparam logic [2:0] MISC_NOP  = 3'b000;
  localparam logic [2:0] MISC_HALT = 3'b111;

endpackage

// File: rtl/cpu_branch_cond.sv
// Jump condition evaluation against the latched {z,n,c,v} status.
module cpu_branch_cond
  import cpu_pkg::*;
(
  input  logic [3:0] i_status,
  input  logic [2:0] i_cond,
  output logic       o_taken
);

  logic w_z, w_n, w_c, w_unused_v;

  assign w_z        = i_status[3];
  assign w_n        = i_status[2];
  assign w_c        = i_status[1];
  assign w_unused_v = i_status[0];

  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      JC_ALWAYS: o_taken = 1'b1;
      JC_Z:      o_taken = w_z;
      JC_NZ:     o_taken = ~w_z;
      JC_GT:     o_taken = ~w_n & ~w_z;
      JC_N:      o_taken = w_n;
      JC_NN:     o_taken = ~w_n;
      JC_LE:     o_taken = w_n | w_z;
      JC_C:      o_taken = w_c;
      default:   o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Fetch/decode/execute controller driving the ALU datapath (3 cycles per instruction).
// Defining CPU_SINGLE_STEP_EN adds a step input and a STEP_WAIT state after EXEC.
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int unsigned     PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
`ifdef CPU_SINGLE_STEP_EN
  input  logic            step,
`endif
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  output logic [2:0]      alu_s,
  output logic            sel_b,
  output logic            sel_a,
  output logic [7:0]      lit,
  output logic            la,
  output logic            lb,
  input  logic            z,
  input  logic            n,
  input  logic            c,
  input  logic            v,
  output logic [3:0]      status,
  output logic [PC_W-1:0] pc,
  output logic            halted
);

  state_t          r_state, w_next;
  logic [PC_W-1:0] r_pc, w_pc_next, w_pc_inc, w_target;
  logic [15:0]     r_ir;
  logic [3:0]      r_status;
  logic [1:0]      w_cls;
  logic [2:0]      w_sub;
  logic            w_status_we, w_taken, w_is_halt;

  assign w_cls     = r_ir[15:14];
  assign w_sub     = r_ir[10:8];
  assign w_pc_inc  = r_pc + PC_W'(1);
  assign w_target  = PC_W'(r_ir[7:0]);
  assign w_is_halt = (w_cls == CLS_MISC) && (w_sub == MISC_HALT);

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign status    = r_status;
  assign halted    = (r_state == ST_HALT);

  cpu_branch_cond u_branch_cond (
    .i_status (r_status),
    .i_cond   (w_sub),
    .o_taken  (w_taken)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   w_next = run ? ST_FETCH : ST_IDLE;
      ST_FETCH:  w_next = ST_DECODE;
      ST_DECODE: w_next = ST_EXEC;
      ST_EXEC: begin
        if (w_is_halt) w_next = ST_HALT;
`ifdef CPU_SINGLE_STEP_EN
        else           w_next = ST_STEP_WAIT;
`else
        else           w_next = run ? ST_FETCH : ST_IDLE;
`endif
      end
      ST_HALT:   w_next = ST_HALT;
`ifdef CPU_SINGLE_STEP_EN
      ST_STEP_WAIT: w_next = step ? ST_FETCH : ST_STEP_WAIT;
`endif
      default:   w_next = ST_IDLE;
    endcase
  end

  // Datapath controls are only non-zero in EXEC; NOP encodings leave loads and status alone.
  always_comb begin
    la          = 1'b0;
    lb          = 1'b0;
    sel_a       = 1'b0;
    sel_b       = 1'b0;
    alu_s       = 3'd0;
    lit         = 8'd0;
    w_status_we = 1'b0;
    w_pc_next   = r_pc;
    if (r_state == ST_EXEC) begin
      alu_s = r_ir[13:11];
      lit   = r_ir[7:0];
      case (w_cls)
        CLS_ALU_A: begin
          w_pc_next = w_pc_inc;
          if (w_sub == SRC_B || w_sub == SRC_LIT) begin
            la          = 1'b1;
            sel_b       = (w_sub == SRC_LIT);
            w_status_we = 1'b1;
          end else begin
            la = 1'b0;
          end
        end
        CLS_ALU_B: begin
          w_pc_next = w_pc_inc;
          sel_a     = 1'b1;
          if (w_sub == SRC_B || w_sub == SRC_LIT) begin
            lb          = 1'b1;
            sel_b       = (w_sub == SRC_LIT);
            w_status_we = 1'b1;
          end else begin
            lb = 1'b0;
          end
        end
        CLS_JMP:  w_pc_next = w_taken ? w_target : w_pc_inc;
        CLS_MISC: w_pc_next = w_is_halt ? r_pc : w_pc_inc;
        default:  w_pc_next = r_pc;
      endcase
    end else begin
      w_pc_next = r_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_ir     <= 16'd0;
      r_status <= 4'd0;
    end else begin
      if (r_state == ST_DECODE) r_ir <= imem_data;
      if (r_state == ST_EXEC)   r_pc <= w_pc_next;
      if (w_status_we)          r_status <= {z, n, c, v};
    end
  end

endmodule
